uart_bus_sequencer: RTL and testbench

Controller that owns the `simple_uart` register bus (DR at address 0, SR at address 1) and sequences every access to it. It shares the single transmitter between `N_REQ` byte requesters with round-robin arbitration and drains the receiver into a one-byte holding buffer with a valid/ready output. It sits between the `simple_uart` instance and its on-chip clients, replacing direct CPU polling of the UART.

---
 rtl/uart_bus_sequencer.sv | 129 ++++++++++++
 tb/tb_uart_bus_sequencer.sv | 434 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_bus_sequencer.sv
// Owns the simple_uart register bus: round-robin sharing of the transmitter
// between N_REQ byte requesters and a one-byte receive buffer with valid/ready.
module uart_bus_sequencer #(
  parameter int N_REQ = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [N_REQ-1:0]     tx_valid_i,
  input  logic [8*N_REQ-1:0]   tx_data_i,
  output logic [N_REQ-1:0]     tx_ready_o,
  output logic                 rx_valid_o,
  output logic [7:0]           rx_data_o,
  input  logic                 rx_ready_i,
  output logic                 uart_addr_o,
  output logic [7:0]           uart_d_o,
  output logic                 uart_sel_o,
  output logic                 uart_we_o,
  input  logic [7:0]           uart_q_i
);

  // state | meaning
  // POLL  | read SR every cycle, choose RX service or TX load
  // RXRD  | read DR into the holding buffer
  // RXCLR | write SR to clear BITRCVD
  // TXWR  | write the granted byte to DR, pulse its tx_ready_o
  // TXGAP | bus idle one cycle so TXBUSY is visible to the next poll

  localparam int IW = $clog2(N_REQ);

  typedef enum logic [2:0] {
    POLL  = 3'd0,
    RXRD  = 3'd1,
    RXCLR = 3'd2,
    TXWR  = 3'd3,
    TXGAP = 3'd4
  } state_e;

  state_e           state;
  logic [IW-1:0]    rr_ptr;
  logic [IW-1:0]    grant_q;
  logic [IW-1:0]    grant_nxt;
  logic [N_REQ-1:0] grant_oh;
  logic [7:0]       tx_byte;
  logic             rx_full;
  logic [7:0]       rx_data;
  logic             rx_go;
  logic             tx_go;

  function automatic logic [IW-1:0] wrap_idx(input int a);
    if (a >= N_REQ) return IW'(a - N_REQ);
    return IW'(a);
  endfunction

  // Scan from the far end so the last hit is the one closest to rr_ptr.
  always_comb begin
    grant_nxt = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (tx_valid_i[wrap_idx(int'(rr_ptr) + k)]) grant_nxt = wrap_idx(int'(rr_ptr) + k);
    end
  end

  always_comb begin
    grant_oh = '0;
    grant_oh[grant_nxt] = 1'b1;
  end

  assign tx_byte = tx_data_i[8*int'(grant_nxt) +: 8];

  // Registered rx_full keeps a same-edge pop from starting a read one cycle early.
  assign rx_go = uart_q_i[0] & ~rx_full;
  assign tx_go = ~uart_q_i[1] & (|tx_valid_i);

  assign rx_valid_o = rx_full;
  assign rx_data_o  = rx_data;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= POLL;
      rr_ptr      <= '0;
      grant_q     <= '0;
      rx_full     <= 1'b0;
      rx_data     <= '0;
      tx_ready_o  <= '0;
      uart_sel_o  <= 1'b1;
      uart_we_o   <= 1'b0;
      uart_addr_o <= 1'b1;
      uart_d_o    <= '0;
    end else begin
      // Outputs below are those of the state being entered; POLL is the default.
      tx_ready_o  <= '0;
      uart_sel_o  <= 1'b1;
      uart_we_o   <= 1'b0;
      uart_addr_o <= 1'b1;
      uart_d_o    <= '0;
      if (rx_full && rx_ready_i) rx_full <= 1'b0;
      case (state)
        POLL: begin
          if (rx_go) begin
            state       <= RXRD;
            uart_addr_o <= 1'b0;
          end else if (tx_go) begin
            state       <= TXWR;
            grant_q     <= grant_nxt;
            uart_we_o   <= 1'b1;
            uart_addr_o <= 1'b0;
            uart_d_o    <= tx_byte;
            tx_ready_o  <= grant_oh;
          end
        end
        RXRD: begin
          rx_data   <= uart_q_i;
          rx_full   <= 1'b1;
          state     <= RXCLR;
          uart_we_o <= 1'b1;
        end
        RXCLR: state <= POLL;
        TXWR: begin
          rr_ptr      <= (grant_q == IW'(N_REQ - 1)) ? '0 : grant_q + IW'(1);
          state       <= TXGAP;
          uart_sel_o  <= 1'b0;
          uart_addr_o <= 1'b0;
        end
        TXGAP: state <= POLL;
        default: state <= POLL;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_bus_sequencer.sv
// Bench for uart_bus_sequencer: behavioural simple_uart register model,
// requester drivers and a rule-level scoreboard for arbitration and RX delivery.
module tb_uart_bus_sequencer;

  localparam int N        = 4;
  localparam int BUSY_CYC = 40;

  logic             clk = 1'b0;
  logic             rst_ni = 1'b0;
  logic [N-1:0]     tx_valid = '0;
  logic [8*N-1:0]   tx_data = '0;
  logic [N-1:0]     tx_ready;
  logic             rx_valid;
  logic [7:0]       rx_data;
  logic             rx_ready = 1'b0;
  logic             uart_addr;
  logic [7:0]       uart_d;
  logic             uart_sel;
  logic             uart_we;
  logic [7:0]       uart_q;
  logic [2:0]       bus;

  always #5 clk = ~clk;

  uart_bus_sequencer #(.N_REQ(N)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .tx_valid_i  (tx_valid),
    .tx_data_i   (tx_data),
    .tx_ready_o  (tx_ready),
    .rx_valid_o  (rx_valid),
    .rx_data_o   (rx_data),
    .rx_ready_i  (rx_ready),
    .uart_addr_o (uart_addr),
    .uart_d_o    (uart_d),
    .uart_sel_o  (uart_sel),
    .uart_we_o   (uart_we),
    .uart_q_i    (uart_q)
  );

  // {sel,we,addr}: 101 poll, 100 DR read, 111 SR clear, 110 DR write, 000 idle
  assign bus = {uart_sel, uart_we, uart_addr};

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- simple_uart register model (no reset) ----------------
  logic       txbusy = 1'b0;
  logic       bitrcvd = 1'b0;
  logic [7:0] rx_dr = '0;
  int         busy_cnt = 0;
  int         inj_done = 0;
  logic [7:0] rx_exp[$];

  assign uart_q = uart_addr ? {6'b0, txbusy, bitrcvd} : rx_dr;

  initial begin
    logic [2:0] s_bus;
    forever begin
      @(negedge clk);
      s_bus = bus;
      @(posedge clk);
      #1;
      if (rst_ni && s_bus == 3'b110) begin
        txbusy   = 1'b1;
        busy_cnt = BUSY_CYC;
      end else if (txbusy) begin
        busy_cnt--;
        if (busy_cnt == 0) txbusy = 1'b0;
      end
      if (rst_ni && s_bus == 3'b111) bitrcvd = 1'b0;
      if (inj_done < rx_exp.size()) begin
        rx_dr   = rx_exp[inj_done];
        bitrcvd = 1'b1;
        inj_done++;
      end
    end
  end

  // ---------------- requesters ----------------
  logic [7:0] req_mem [N][16];
  int req_wr [N] = '{default: 0};
  int req_rd [N] = '{default: 0};
  int enq_total = 0;
  int acc_cnt = 0;

  initial begin
    logic [N-1:0] rdy;
    forever begin
      @(negedge clk);
      rdy = tx_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (rst_ni && rdy[i] && tx_valid[i]) begin
          tx_valid[i] = 1'b0;
          acc_cnt++;
        end
        if (!tx_valid[i] && req_rd[i] < req_wr[i]) begin
          tx_data[8*i +: 8] = req_mem[i][req_rd[i] % 16];
          req_rd[i]++;
          tx_valid[i] = 1'b1;
        end
      end
    end
  end

  task automatic enq(input int i, input logic [7:0] b);
    req_mem[i][req_wr[i] % 16] = b;
    req_wr[i]++;
    enq_total++;
  endtask

  task automatic push_rx(input logic [7:0] b);
    rx_exp.push_back(b);
  endtask

  // ---------------- reference model / scoreboard ----------------
  int m_ptr = 0;
  int cap_idx = 0;
  int pop_idx = 0;
  int rd_cnt = 0;
  int clr_cnt = 0;
  int grant_log[$];
  int ev_log[$];

  function automatic int rr_first(input logic [N-1:0] v, input int ptr);
    for (int k = 0; k < N; k++) begin
      if (v[(ptr + k) % N]) return (ptr + k) % N;
    end
    return 0;
  endfunction

  function automatic int oh_idx(input logic [N-1:0] v);
    for (int k = 0; k < N; k++) if (v == (N'(1) << k)) return k;
    return 99;
  endfunction

  function automatic logic [31:0] exp_at(input int k);
    if (k < rx_exp.size()) return 32'(rx_exp[k]);
    return 32'hdead;
  endfunction

  function automatic int ev_at(input int k);
    if (k < ev_log.size()) return ev_log[k];
    return 99;
  endfunction

  function automatic int glog_at(input int k);
    if (k < grant_log.size()) return grant_log[k];
    return 99;
  endfunction

  initial begin
    logic           have_prev;
    logic [2:0]     prev_bus;
    logic [2:0]     exp_bus;
    logic [7:0]     prev_q;
    logic [N-1:0]   prev_valid;
    logic [8*N-1:0] prev_data;
    logic           prev_rxv;
    int             g;
    have_prev = 1'b0;
    prev_bus = 3'b101;
    prev_q = '0;
    prev_valid = '0;
    prev_data = '0;
    prev_rxv = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_ni) begin
        have_prev = 1'b0;
        m_ptr = 0;
      end else begin
        if (have_prev) begin
          case (prev_bus)
            3'b101: begin
              if (prev_q[0] && !prev_rxv) exp_bus = 3'b100;
              else if (!prev_q[1] && prev_valid != '0) exp_bus = 3'b110;
              else exp_bus = 3'b101;
              check_val("poll_next", 32'(bus), 32'(exp_bus));
            end
            3'b100:  check_val("rd_next", 32'(bus), 32'b111);
            3'b111:  check_val("clr_next", 32'(bus), 32'b101);
            3'b110:  check_val("wr_next", 32'(bus), 32'b000);
            default: check_val("gap_next", 32'(bus), 32'b101);
          endcase
        end
        if (bus == 3'b110 && have_prev) begin
          g = rr_first(prev_valid, m_ptr);
          check_val("tx_grant", 32'(tx_ready), 32'(1) << g);
          check_val("tx_data", 32'(uart_d), 32'(prev_data[8*g +: 8]));
          check_val("tx_busy_clear", 32'(prev_q[1]), 0);
          check_val("tx_no_rx_pending", 32'(prev_q[0] & ~prev_rxv), 0);
          m_ptr = (g + 1) % N;
          grant_log.push_back(oh_idx(tx_ready));
          ev_log.push_back(3);
        end else begin
          check_val("tx_ready_quiet", 32'(tx_ready), 0);
          check_val("d_zero", 32'(uart_d), 0);
        end
        if (bus == 3'b100) begin
          rd_cnt++;
          ev_log.push_back(1);
        end
        if (bus == 3'b111) begin
          clr_cnt++;
          ev_log.push_back(2);
          check_val("rx_valid_set", 32'(rx_valid), 1);
          check_val("rx_cap_data", 32'(rx_data), exp_at(cap_idx));
          cap_idx++;
        end
        if (rx_valid && rx_ready) begin
          check_val("rx_pop_data", 32'(rx_data), exp_at(pop_idx));
          pop_idx++;
        end
        prev_bus   = bus;
        prev_q     = uart_q;
        prev_valid = tx_valid;
        prev_data  = tx_data;
        prev_rxv   = rx_valid;
        have_prev  = 1'b1;
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic wait_idle();
    int n;
    n = 0;
    while (n < 6000 && !(tx_valid == '0 && !txbusy && !rx_valid && !bitrcvd &&
                         inj_done == rx_exp.size() && bus == 3'b101)) begin
      @(negedge clk);
      n++;
    end
    check_val("idle_reached", 32'(n < 6000), 1);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    #2 rst_ni = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3 rst_ni = 1'b1;
  endtask

  task automatic pop_one();
    @(posedge clk);
    #1 rx_ready = 1'b1;
    @(posedge clk);
    #1 rx_ready = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int bad;
    int n;
    int r0;
    int c0;
    int exp_rr[5];
    exp_rr = '{0, 1, 2, 3, 0};

    #12;
    check_val("rst_sel", 32'(uart_sel), 1);
    check_val("rst_addr", 32'(uart_addr), 1);
    check_val("rst_we", 32'(uart_we), 0);
    check_val("rst_d", 32'(uart_d), 0);
    check_val("rst_ready", 32'(tx_ready), 0);
    check_val("rst_rx_valid", 32'(rx_valid), 0);
    check_val("rst_rx_data", 32'(rx_data), 0);
    @(posedge clk);
    #3 rst_ni = 1'b1;

    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (bus != 3'b101 || tx_ready != '0) bad++;
    end
    check_val("idle_poll", bad, 0);

    // single byte from requester 2
    @(negedge clk);
    enq(2, 8'h55);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!tx_valid[2] && n < 50);
    check_val("tx_req_seen", 32'(tx_valid[2]), 1);
    @(negedge clk);
    check_val("tx_lat_wr", 32'(bus), 32'b110);
    check_val("tx_lat_d", 32'(uart_d), 32'h55);
    check_val("tx_lat_rdy", 32'(tx_ready), 32'b0100);
    @(negedge clk);
    check_val("tx_lat_gap", 32'(bus), 32'b000);
    check_val("tx_gap_rdy", 32'(tx_ready), 0);
    @(negedge clk);
    check_val("tx_lat_poll", 32'(bus), 32'b101);
    check_val("tx_busy_seen", 32'(uart_q[1]), 1);
    wait_idle();

    // all four requesters, grant order after reset
    pulse_reset();
    grant_log.delete();
    @(negedge clk);
    for (int i = 0; i < N; i++) enq(i, 8'hA0 + 8'(i));
    enq(0, 8'hA4);
    n = 0;
    while (grant_log.size() < 5 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    for (int k = 0; k < 5; k++) check_val($sformatf("rr_order_%0d", k), glog_at(k), exp_rr[k]);
    wait_idle();

    // RX byte held while consumer stalls
    @(negedge clk);
    r0 = rd_cnt;
    c0 = clr_cnt;
    push_rx(8'h3C);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(bus == 3'b101 && uart_q[0]) && n < 50);
    check_val("rx_sr_seen", 32'(uart_q[0]), 1);
    @(negedge clk);
    check_val("rx_lat_rd", 32'(bus), 32'b100);
    check_val("rx_lat_notyet", 32'(rx_valid), 0);
    @(negedge clk);
    check_val("rx_lat_clr", 32'(bus), 32'b111);
    check_val("rx_lat_valid", 32'(rx_valid), 1);
    check_val("rx_lat_data", 32'(rx_data), 32'h3C);
    @(negedge clk);
    check_val("rx_lat_poll", 32'(bus), 32'b101);
    repeat (20) @(negedge clk);
    check_val("rx_clr_once", clr_cnt - c0, 1);
    push_rx(8'h7E);
    repeat (20) @(negedge clk);
    check_val("rx_held_no_read", rd_cnt - r0, 1);
    check_val("rx_held_data", 32'(rx_data), 32'h3C);
    check_val("rx_pending", 32'(bitrcvd), 1);
    pop_one();
    n = 0;
    while (!rx_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_val("rx_second", 32'(rx_data), 32'h7E);
    check_val("rx_second_read", rd_cnt - r0, 2);
    pop_one();
    wait_idle();

    // RX service precedes a simultaneously pending TX
    @(negedge clk);
    ev_log.delete();
    enq(1, 8'h5A);
    push_rx(8'hC3);
    repeat (30) @(negedge clk);
    check_val("prio_first_rd", ev_at(0), 1);
    check_val("prio_then_clr", ev_at(1), 2);
    check_val("prio_then_wr", ev_at(2), 3);
    pop_one();
    wait_idle();

    // reset while a DR write is on the bus
    @(negedge clk);
    enq(1, 8'h11);
    enq(3, 8'h33);
    n = 0;
    while (bus != 3'b110 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_val("rst_pre_grant", 32'(tx_ready), 32'b1000);
    #2 rst_ni = 1'b0;
    #1;
    check_val("rst_abort_we", 32'(uart_we), 0);
    check_val("rst_abort_sel", 32'(uart_sel), 1);
    check_val("rst_abort_addr", 32'(uart_addr), 1);
    check_val("rst_abort_d", 32'(uart_d), 0);
    check_val("rst_abort_rdy", 32'(tx_ready), 0);
    @(posedge clk);
    @(posedge clk);
    #3 rst_ni = 1'b1;
    grant_log.delete();
    n = 0;
    while (grant_log.size() < 1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_val("rst_regrant", glog_at(0), 1);
    wait_idle();

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 19) == 0) begin
        int i;
        i = int'($urandom_range(0, N - 1));
        if (req_wr[i] - req_rd[i] < 8) enq(i, 8'($urandom));
      end
      if (!bitrcvd && inj_done == rx_exp.size() && $urandom_range(0, 29) == 0)
        push_rx(8'($urandom));
      @(posedge clk);
      #1 rx_ready = ($urandom_range(0, 3) == 0);
    end
    @(posedge clk);
    #1 rx_ready = 1'b1;
    n = 0;
    while (n < 8000 && !(acc_cnt == enq_total && pop_idx == rx_exp.size() &&
                         inj_done == rx_exp.size())) begin
      @(negedge clk);
      n++;
    end
    check_val("tx_all_accepted", acc_cnt, enq_total);
    check_val("rx_all_popped", pop_idx, rx_exp.size());
    @(posedge clk);
    #1 rx_ready = 1'b0;
    repeat (5) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
